output_fifo_packer: RTL and testbench

//  Upstream feeder for the output_io FIFO write slave (output_fifo_in_*).

---
 rtl/output_io_pkg.sv | 17 +
 rtl/output_fifo_packer_if.sv | 28 ++
 rtl/output_word_packer.sv | 40 ++++
 rtl/output_fifo_packer.sv | 101 ++++++++++
 tb/tb_output_fifo_packer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/output_io_pkg.sv
// Shared types and constants for the output_io FIFO feeder path.
package output_io_pkg;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int NUM_LANES  = WORD_W / BYTE_W;
  localparam int LANE_CNT_W = $clog2(NUM_LANES) + 1;

  // CSR register map of the downstream FIFO write slave
  localparam logic [2:0] FILL_LEVEL_ADDR = 3'd0;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_POLL_REQ  = 2'd2,
    ST_POLL_WAIT = 2'd3
  } state_e;
endpackage

// File: rtl/output_fifo_packer_if.sv
// Byte stream in, Avalon-MM write + CSR port out, plus status.
// master: the packer side; slave: the core/FIFO environment side.
interface output_fifo_packer_if;
  import output_io_pkg::*;
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_flush;
  logic [WORD_W-1:0] fifo_writedata;
  logic              fifo_write;
  logic              fifo_waitrequest;
  logic [2:0]        fifo_csr_address;
  logic              fifo_csr_read;
  logic [WORD_W-1:0] fifo_csr_readdata;
  logic              busy;
  logic [31:0]       words_written;

  modport master (
    input  in_data, in_valid, in_flush, fifo_waitrequest, fifo_csr_readdata,
    output in_ready, fifo_writedata, fifo_write, fifo_csr_address, fifo_csr_read,
           busy, words_written
  );
  modport slave (
    output in_data, in_valid, in_flush, fifo_waitrequest, fifo_csr_readdata,
    input  in_ready, fifo_writedata, fifo_write, fifo_csr_address, fifo_csr_read,
           busy, words_written
  );
endinterface

// File: rtl/output_word_packer.sv
// Byte-lane collector: places byte k in lane k, counts bytes, and presents the
// (possibly padded) word in the same cycle the 4th byte or a flush arrives.
module output_word_packer
  import output_io_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
  input  logic                                gclk,
  input  logic                                grst_n,
  input  logic                                accept,   // byte taken this cycle
  input  logic [BYTE_W-1:0]                   data,
  input  logic                                flush,    // already qualified to FILL
  input  logic                                clear,    // word written out
  output logic [LANE_CNT_W-1:0]               count,
  output logic                                word_rdy,
  output logic [NUM_LANES-1:0][BYTE_W-1:0]    word
);
  logic [NUM_LANES-1:0][BYTE_W-1:0] lanes, lanes_nxt;
  logic [LANE_CNT_W-1:0]            cnt_nxt;

  // count includes a byte arriving alongside a flush, so it lands before padding
  assign cnt_nxt  = count + LANE_CNT_W'(accept);
  assign word_rdy = (cnt_nxt == LANE_CNT_W'(NUM_LANES)) || (flush && cnt_nxt != '0);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lanes_nxt[k] = (accept && count == LANE_CNT_W'(k)) ? data : lanes[k];
    assign word[k]      = (LANE_CNT_W'(k) < cnt_nxt) ? lanes_nxt[k] : PAD_BYTE;
  end

  // lane storage; stale lanes are masked by the count, so no clear needed
  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) lanes <= '0;
    else         lanes <= lanes_nxt;

  // byte count holds through the write so busy stays high until it completes
  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n)     count <= '0;
    else if (clear)  count <= '0;
    else if (accept) count <= cnt_nxt;
endmodule

// File: rtl/output_fifo_packer.sv
// Packs an 8-bit stream into 32-bit LE words and writes them to the output_io
// FIFO over Avalon-MM. Build option OUTPUT_FIFO_LEVEL_POLL_EN adds a write
// credit refreshed from the FIFO fill-level CSR so writes never stall the bus.
module output_fifo_packer
  import output_io_pkg::*;
#(
  parameter int               FIFO_DEPTH = 256,
  parameter logic [BYTE_W-1:0] PAD_BYTE  = 8'h00
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  output_fifo_packer_if.master bus
);
  localparam logic [31:0] DEPTH_W = FIFO_DEPTH;

  state_e                           state;
  logic                             in_ready_q, wr_q, csr_rd_q;
  logic [WORD_W-1:0]                wdata_q;
  logic [31:0]                      words_q;
  logic                             accept, done, word_rdy, need_poll;
  logic [LANE_CNT_W-1:0]            count;
  logic [NUM_LANES-1:0][BYTE_W-1:0] word;

  assign accept = bus.in_valid && in_ready_q;
  assign done   = (state == ST_WRITE) && !bus.fifo_waitrequest;

  output_word_packer #(.PAD_BYTE(PAD_BYTE)) u_pack (
    .gclk     (clk_clk),
    .grst_n   (reset_reset_n),
    .accept   (accept),
    .data     (bus.in_data),
    .flush    (bus.in_flush && state == ST_FILL),
    .clear    (done),
    .count    (count),
    .word_rdy (word_rdy),
    .word     (word)
  );

`ifdef OUTPUT_FIFO_LEVEL_POLL_EN
  logic [31:0] credit, credit_rd, fill_lvl;
  logic        unused_rd;
  assign fill_lvl  = {16'd0, bus.fifo_csr_readdata[15:0]};
  assign credit_rd = (DEPTH_W > fill_lvl) ? DEPTH_W - fill_lvl : '0;
  assign need_poll = (credit == '0);
  assign unused_rd = ^bus.fifo_csr_readdata[31:16];

  // credit: reloaded from each fill-level read, one spent per completed write
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n)                  credit <= '0;
    else if (state == ST_POLL_WAIT)      credit <= credit_rd;
    else if (done && credit != '0)       credit <= credit - 32'd1;
`else
  logic unused_csr;
  assign need_poll  = 1'b0;
  assign unused_csr = ^{bus.fifo_csr_readdata, DEPTH_W};
`endif

  // control FSM with registered handshake and bus outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state      <= ST_FILL;
      in_ready_q <= 1'b1;
      wr_q       <= 1'b0;
      csr_rd_q   <= 1'b0;
      wdata_q    <= '0;
      words_q    <= '0;
    end else begin
      case (state)
        ST_FILL: if (word_rdy) begin
          wdata_q    <= word;
          in_ready_q <= 1'b0;
          if (need_poll) begin state <= ST_POLL_REQ; csr_rd_q <= 1'b1; end
          else           begin state <= ST_WRITE;    wr_q     <= 1'b1; end
        end
        ST_WRITE: if (!bus.fifo_waitrequest) begin
          state      <= ST_FILL;
          wr_q       <= 1'b0;
          in_ready_q <= 1'b1;
          words_q    <= words_q + 32'd1;
        end
`ifdef OUTPUT_FIFO_LEVEL_POLL_EN
        ST_POLL_REQ: begin
          state    <= ST_POLL_WAIT;
          csr_rd_q <= 1'b0;
        end
        ST_POLL_WAIT:
          if (credit_rd == '0) begin state <= ST_POLL_REQ; csr_rd_q <= 1'b1; end
          else                 begin state <= ST_WRITE;    wr_q     <= 1'b1; end
`endif
        default: state <= ST_FILL;
      endcase
    end

  assign bus.in_ready         = in_ready_q;
  assign bus.fifo_write       = wr_q;
  assign bus.fifo_writedata   = wdata_q;
  assign bus.fifo_csr_read    = csr_rd_q;
  assign bus.fifo_csr_address = FILL_LEVEL_ADDR;
  assign bus.words_written    = words_q;
  assign bus.busy             = (count != '0) || (state != ST_FILL);
endmodule

// File: tb/tb_output_fifo_packer.sv
// Self-checking bench for output_fifo_packer: directed cases plus a random
// byte/flush/waitrequest run scored against a byte-list model of the packer.
module tb_output_fifo_packer;
  logic gclk = 1'b0;
  logic grst_n;
  always #5 gclk = ~gclk;

  output_fifo_packer_if bus();
  output_fifo_packer dut (.clk_clk(gclk), .reset_reset_n(grst_n), .bus(bus));

  int n_chk = 0, n_err = 0;
  logic rand_wr = 1'b0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  part[$];
  int poll_cnt = 0, poll_first = -1, addr_bad = 0;
  logic [31:0] first_fill = 0, next_fill = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk); #1;
    if (rand_wr) bus.fifo_waitrequest = ($urandom_range(0, 2) == 0);
  endtask

  // observe completed writes
  always @(negedge gclk)
    if (grst_n && bus.fifo_write && !bus.fifo_waitrequest) obs_q.push_back(bus.fifo_writedata);

  // CSR slave: fill level appears in the cycle after the read
  always @(negedge gclk)
    if (bus.fifo_csr_read) begin
      bus.fifo_csr_readdata <= (poll_cnt == poll_first) ? first_fill : next_fill;
      poll_cnt <= poll_cnt + 1;
      if (bus.fifo_csr_address != 3'd0) addr_bad <= addr_bad + 1;
    end

  // reference: bytes collect in order, a full or flushed list becomes a word
  function automatic logic [31:0] pack_model();
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = (i < part.size()) ? part[i] : 8'h00;
    return w;
  endfunction

  task automatic model_step(input logic [7:0] b, input logic v, input logic fl);
    if (v) part.push_back(b);
    if (part.size() == 4 || (fl && part.size() > 0)) begin
      exp_q.push_back(pack_model());
      part.delete();
    end
  endtask

  // present one beat; waits (bounded) for in_ready, so flush always lands in FILL
  task automatic put(input logic [7:0] b, input logic v, input logic fl);
    int t = 0;
    bus.in_data = b; bus.in_valid = v; bus.in_flush = fl;
    while (!bus.in_ready && t < 100) begin tick(); t++; end
    if (t >= 100) chk("ready_timeout", 32'(t), 32'd0);
    model_step(b, v, fl);
    tick();
    bus.in_valid = 1'b0; bus.in_flush = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 300) begin tick(); t++; end
    chk("idle_timeout", 32'(t < 300), 32'd1);
  endtask

  task automatic do_reset();
    grst_n = 1'b0; tick(); tick(); grst_n = 1'b1; tick();
    part.delete(); exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_flush = 1'b0;
    bus.fifo_waitrequest = 1'b0;
    grst_n = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_write",    32'(bus.fifo_write), 32'd0);
    chk("rst_wdata",    bus.fifo_writedata, 32'd0);
    chk("rst_busy",     32'(bus.busy), 32'd0);
    chk("rst_words",    bus.words_written, 32'd0);
    chk("rst_csr_read", 32'(bus.fifo_csr_read), 32'd0);
    grst_n = 1'b1; tick();
`ifdef OUTPUT_FIFO_LEVEL_POLL_EN
    next_fill = 0;  // plenty of credit for the directed part
`endif

    // 1: full word, write one cycle after the 4th byte
    put(8'h11, 1, 0); put(8'h22, 1, 0); put(8'h33, 1, 0);
    chk("t1_busy_partial", 32'(bus.busy), 32'd1);
    put(8'h44, 1, 0);
`ifndef OUTPUT_FIFO_LEVEL_POLL_EN
    chk("t1_write",    32'(bus.fifo_write), 32'd1);
    chk("t1_wdata",    bus.fifo_writedata, 32'h44332211);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("t1_words",    bus.words_written, 32'd1);
    chk("t1_ready_up", 32'(bus.in_ready), 32'd1);
`endif
    wait_idle();

    // 2: flushed partial word is padded
    put(8'hAA, 1, 0); put(8'hBB, 1, 0); put(8'h00, 0, 1);
    wait_idle();
    chk("t2_words", bus.words_written, 32'd2);
    chk("t2_busy",  32'(bus.busy), 32'd0);
    chk("t2_last",  obs_q[obs_q.size()-1], 32'h0000BBAA);

    // 3: waitrequest stall keeps the write stable; flush/valid ignored meanwhile
    bus.fifo_waitrequest = 1'b1;
    put(8'h01, 1, 0); put(8'h02, 1, 0); put(8'h03, 1, 0); put(8'h04, 1, 0);
    while (!bus.fifo_write) tick();
    bus.in_valid = 1'b1; bus.in_flush = 1'b1; bus.in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      chk("t3_wdata",    bus.fifo_writedata, 32'h04030201);
      chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t3_words",    bus.words_written, 32'd2);
      tick();
    end
    bus.in_valid = 1'b0; bus.in_flush = 1'b0; bus.fifo_waitrequest = 1'b0;
    tick();
    chk("t3_words_after", bus.words_written, 32'd3);
    tick();
    chk("t3_no_extra", 32'(bus.fifo_write), 32'd0);
    chk("t3_idle",     32'(bus.busy), 32'd0);

    // 4: flush together with the 4th byte -> one full word only
    put(8'hC1, 1, 0); put(8'hC2, 1, 0); put(8'hC3, 1, 0); put(8'hC4, 1, 1);
    wait_idle(); tick(); tick();
    chk("t4_words", bus.words_written, 32'd4);
    chk("t4_word",  obs_q[obs_q.size()-1], 32'hC4C3C2C1);
    chk("t4_model", 32'(exp_q.size()), 32'd4);

    // 5: reset mid-write drops the word
    bus.fifo_waitrequest = 1'b1;
    put(8'hD1, 1, 0); put(8'hD2, 1, 0); put(8'hD3, 1, 0); put(8'hD4, 1, 0);
    while (!bus.fifo_write) tick();
    grst_n = 1'b0; #1;
    chk("t5_write_drop", 32'(bus.fifo_write), 32'd0);
    chk("t5_in_ready",   32'(bus.in_ready), 32'd1);
    chk("t5_words",      bus.words_written, 32'd0);
    tick(); grst_n = 1'b1; bus.fifo_waitrequest = 1'b0;
    part.delete(); exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("t5_no_stale", 32'(obs_q.size()), 32'd0);
    chk("t5_busy",     32'(bus.busy), 32'd0);

    // random bytes, flushes and waitrequest
    rand_wr = 1'b1;
    for (int i = 0; i < 300; i++)
      put(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 6) == 0);
    put(8'h00, 0, 1);
    rand_wr = 1'b0; bus.fifo_waitrequest = 1'b0;
    wait_idle();
    chk("rnd_count", 32'(obs_q.size()), 32'(exp_q.size()));
    chk("rnd_words", bus.words_written, 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) chk($sformatf("rnd_word%0d", i), obs_q[i], exp_q[i]);
    chk("rnd_words_match", 32'(obs_q == exp_q), 32'd1);

`ifdef OUTPUT_FIFO_LEVEL_POLL_EN
    // 6: fill 256 -> no credit, re-poll; fill 250 -> six writes, then poll again
    do_reset();
    poll_first = poll_cnt; first_fill = 256; next_fill = 250;
    begin
      int base = poll_cnt;
      for (int w = 0; w < 6; w++)
        for (int k = 0; k < 4; k++) put(8'(16*w + k), 1, 0);
      wait_idle();
      chk("t6_polls",  32'(poll_cnt - base), 32'd2);
      chk("t6_words6", bus.words_written, 32'd6);
      for (int k = 0; k < 4; k++) put(8'hE0 + 8'(k), 1, 0);
      wait_idle();
      chk("t6_repoll", 32'(poll_cnt - base), 32'd3);
      chk("t6_words7", bus.words_written, 32'd7);
      chk("t6_addr",   32'(addr_bad), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
